pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 32: PC and address width in bits.
REQ-002 Parameter STEP, default 1: increment per instruction (word-addressed).
REQ-003 Parameter RESET_VECTOR, default 0: PC value loaded on reset.
REQ-004 Parameter RAS_DEPTH, default 4: return-address-stack entries (power of two, >=2).
REQ-005 clock  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 stall  input  1  hold PC and stack unchanged this cycle.
REQ-008 branchTaken  input  1  conditional branch resolved taken.
REQ-009 branchOffset  input  WIDTH  signed two's-complement offset added to pc+STEP.
REQ-010 jumpEn  input  1  absolute jump to jumpTarget.
REQ-011 jumpTarget  input  WIDTH  absolute jump/call destination.
REQ-012 callEn  input  1  subroutine call: push return address, go to jumpTarget.
REQ-013 retEn  input  1  subroutine return: pop stack into PC.
REQ-014 pc  output  WIDTH  current program counter (registered).
REQ-015 pcPlus  output  WIDTH  pc+STEP modulo 2^WIDTH (combinational from pc).
REQ-016 rasEmpty  output  1  stack holds no entries.
REQ-017 rasFull  output  1  stack holds RAS_DEPTH entries.
REQ-018 rasUnderflow  output  1  one-cycle pulse: retEn accepted while stack empty.

Function
REQ-019 pc SHALL update every unstalled cycle; next-PC priority: retEn > callEn > jumpEn > branchTaken > sequential.
REQ-020 Sequential: pc <= pc+STEP; all arithmetic modulo 2^WIDTH, wrap-around silent (max value + STEP wraps to STEP-1).
REQ-021 Branch: pc <= pc+STEP+branchOffset, modulo 2^WIDTH; negative offsets wrap below 0.
REQ-022 Jump: pc <= jumpTarget.
REQ-023 Call: push pcPlus onto stack, pc <= jumpTarget, same cycle.
REQ-024 Return, stack non-empty: pc <= top entry, entry popped, same cycle.
REQ-025 Return, stack empty: pc <= pc+STEP, rasUnderflow=1 next cycle for exactly one cycle, stack unchanged.
REQ-026 Call with stack full: oldest entry discarded (circular overwrite), new entry becomes top, rasFull stays 1.
REQ-027 callEn and retEn together: return executed, call ignored entirely (no push).
REQ-028 stall=1: pc, stack, count held; rasUnderflow=0; all other control inputs ignored.
REQ-029 rasEmpty/rasFull SHALL be registered-state derived, never both 1; latency from qualifying edge: 0 cycles after update.
REQ-030 Stack occupancy counter SHALL saturate at RAS_DEPTH and never decrement below 0.

Reset
REQ-031 reset=1 SHALL immediately (no clock) set pc=RESET_VECTOR, stack count=0, rasEmpty=1, rasFull=0, rasUnderflow=0.
REQ-032 Reset asserted mid-call/return SHALL abandon the operation; no stale stack entry readable after release.
REQ-033 First rising edge after reset release, unstalled, with no control inputs: pc=RESET_VECTOR+STEP.

Configuration
REQ-034 Macro PC_SEQUENCER_RAS_EN compiles in the return-address stack (REQ-023..027, REQ-030).
REQ-035 With PC_SEQUENCER_RAS_EN defined: behaviour per REQ-023..030.
REQ-036 Without it: callEn acts as jumpEn (no push), retEn ignored (sequential), rasEmpty=1, rasFull=0, rasUnderflow=0 constantly; no stack storage synthesised.

Verification
REQ-037 Reset then 3 idle cycles, defaults -> pc 0,1,2,3; pcPlus always pc+1.
REQ-038 pc=0x10, branchTaken, offset=0xFFFFFFFC (-4) -> pc=0x0D; pc=0xFFFFFFFF idle -> pc=0x00000000.
REQ-039 (RAS_EN) pc=0x20 call target 0x100; pc=0x100 call target 0x200; ret; ret -> pc sequence 0x100,0x200,0x101,0x21, rasEmpty=1 at end.
REQ-040 (RAS_EN) 5 calls into depth-4 stack then 5 rets -> 4 correct returns (newest first), 5th ret gives pc+1 and one-cycle rasUnderflow.
REQ-041 stall=1 for 3 cycles with jumpEn and callEn asserted -> pc and rasEmpty unchanged; simultaneous callEn+retEn with stack 1 deep -> pops, no push.
REQ-042 Assert reset asynchronously between edges during call -> pc=RESET_VECTOR before next edge, rasEmpty=1; macro undefined: callEn target 0x40 -> pc=0x40, retEn -> pc+1.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Control and status bundle for pc_sequencer: the master drives the control
// inputs and samples the program counter and return-stack flags.
interface pc_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             stall;
   logic             branchTaken;
   logic [WIDTH-1:0] branchOffset;
   logic             jumpEn;
   logic [WIDTH-1:0] jumpTarget;
   logic             callEn;
   logic             retEn;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] pcPlus;
   logic             rasEmpty;
   logic             rasFull;
   logic             rasUnderflow;

   // No handshake: control inputs are sampled on every rising edge where stall is low.
   modport master (
      output stall, branchTaken, branchOffset, jumpEn, jumpTarget, callEn, retEn,
      input  pc, pcPlus, rasEmpty, rasFull, rasUnderflow
   );

   modport slave (
      input  stall, branchTaken, branchOffset, jumpEn, jumpTarget, callEn, retEn,
      output pc, pcPlus, rasEmpty, rasFull, rasUnderflow
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential/branch/jump/call/return next-PC selection.
// Define PC_SEQUENCER_RAS_EN to build in the circular return-address stack.
module pc_sequencer #(
   parameter int          WIDTH        = 32,
   parameter int unsigned STEP         = 1,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int          RAS_DEPTH    = 4
) (
   input logic            clock,
   input logic            reset,
   pc_sequencer_if.slave  bus
);
   localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] w_pc_plus;
   logic [WIDTH-1:0] w_branch_pc;
   logic [WIDTH-1:0] w_pc_next;

   assign w_pc_plus   = r_pc + STEP_W;
   assign w_branch_pc = w_pc_plus + bus.branchOffset;

`ifdef PC_SEQUENCER_RAS_EN
   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

   logic [WIDTH-1:0] r_stack [RAS_DEPTH];
   logic [PTR_W-1:0] r_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_underflow;
   logic [PTR_W-1:0] w_top_idx;
   logic             w_has_entry;
   logic             w_push;
   logic             w_pop;
   logic             w_ret_empty;

   // r_ptr is the next write slot; once full it keeps advancing so the oldest entry is overwritten.
   assign w_top_idx   = r_ptr - PTR_W'(1);
   assign w_has_entry = (r_count != '0);
   assign w_pop       = !bus.stall && bus.retEn && w_has_entry;
   assign w_ret_empty = !bus.stall && bus.retEn && !w_has_entry;
   assign w_push      = !bus.stall && bus.callEn && !bus.retEn;

   always_comb begin
      w_pc_next = w_pc_plus;
      if (bus.retEn) begin
         if (w_has_entry) w_pc_next = r_stack[w_top_idx];
      end else if (bus.callEn || bus.jumpEn) begin
         w_pc_next = bus.jumpTarget;
      end else if (bus.branchTaken) begin
         w_pc_next = w_branch_pc;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_ptr       <= '0;
         r_count     <= '0;
         r_underflow <= 1'b0;
      end else begin
         r_underflow <= w_ret_empty;
         if (w_push) begin
            r_ptr <= r_ptr + PTR_W'(1);
            if (r_count != DEPTH_C) r_count <= r_count + CNT_W'(1);
         end else if (w_pop) begin
            r_ptr   <= w_top_idx;
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   // Entries need no reset: an empty count makes every stale slot unreachable.
   always_ff @(posedge clock) begin
      if (w_push) r_stack[r_ptr] <= w_pc_plus;
   end

   assign bus.rasEmpty     = (r_count == '0);
   assign bus.rasFull      = (r_count == DEPTH_C);
   assign bus.rasUnderflow = r_underflow;
`else
   localparam int unused_depth = RAS_DEPTH;
   logic w_unused_ret;

   assign w_unused_ret = bus.retEn;

   always_comb begin
      w_pc_next = w_pc_plus;
      if (bus.callEn || bus.jumpEn) begin
         w_pc_next = bus.jumpTarget;
      end else if (bus.branchTaken) begin
         w_pc_next = w_branch_pc;
      end
   end

   assign bus.rasEmpty     = 1'b1;
   assign bus.rasFull      = 1'b0;
   assign bus.rasUnderflow = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_pc <= RESET_VECTOR;
      end else if (!bus.stall) begin
         r_pc <= w_pc_next;
      end
   end

   assign bus.pc     = r_pc;
   assign bus.pcPlus = w_pc_plus;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected PCs are queued as each step is
// driven and compared after the following rising edge.
module tb_pc_sequencer;
   localparam int W = 32;

   logic clock = 1'b0;
   logic reset = 1'b1;

   pc_sequencer_if #(.WIDTH(W)) bus ();

   pc_sequencer #(
      .WIDTH(W), .STEP(1), .RESET_VECTOR('0), .RAS_DEPTH(4)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   logic [W-1:0] exp_q[$];
   int total  = 0;
   int passed = 0;
   int failed = 0;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic st, input logic br, input logic [W-1:0] off,
                         input logic je, input logic [W-1:0] jt,
                         input logic ce, input logic re);
      bus.stall        = st;
      bus.branchTaken  = br;
      bus.branchOffset = off;
      bus.jumpEn       = je;
      bus.jumpTarget   = jt;
      bus.callEn       = ce;
      bus.retEn        = re;
   endtask

   task automatic step(input string tag, input logic [W-1:0] exp_pc);
      logic [W-1:0] e;
      exp_q.push_back(exp_pc);
      @(posedge clock);
      #1;
      e = exp_q.pop_front();
      check(tag, bus.pc, e);
      check({tag, "_plus"}, bus.pcPlus, e + 1);
      set_in(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic op_idle(input string tag, input logic [W-1:0] exp_pc);
      set_in(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
      step(tag, exp_pc);
   endtask

   task automatic op_jump(input string tag, input logic [W-1:0] t, input logic [W-1:0] exp_pc);
      set_in(1'b0, 1'b0, '0, 1'b1, t, 1'b0, 1'b0);
      step(tag, exp_pc);
   endtask

   task automatic op_branch(input string tag, input logic [W-1:0] off, input logic [W-1:0] exp_pc);
      set_in(1'b0, 1'b1, off, 1'b0, '0, 1'b0, 1'b0);
      step(tag, exp_pc);
   endtask

   task automatic op_call(input string tag, input logic [W-1:0] t, input logic [W-1:0] exp_pc);
      set_in(1'b0, 1'b0, '0, 1'b0, t, 1'b1, 1'b0);
      step(tag, exp_pc);
   endtask

   task automatic op_ret(input string tag, input logic [W-1:0] exp_pc);
      set_in(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      step(tag, exp_pc);
   endtask

   task automatic check_flags(input string tag, input logic emp, input logic full, input logic uf);
      check({tag, "_empty"}, W'(bus.rasEmpty), W'(emp));
      check({tag, "_full"}, W'(bus.rasFull), W'(full));
      check({tag, "_uflow"}, W'(bus.rasUnderflow), W'(uf));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      set_in(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
      #2;
      check("rst_pc", bus.pc, 32'h0);
      check("rst_plus", bus.pcPlus, 32'h1);
      check_flags("rst", 1'b1, 1'b0, 1'b0);
      #10 reset = 1'b0;

      op_idle("idle1", 32'h1);
      op_idle("idle2", 32'h2);
      op_idle("idle3", 32'h3);

      op_jump("jmp10", 32'h10, 32'h10);
      op_branch("br_neg", 32'hFFFF_FFFC, 32'h0D);
      op_branch("br_pos", 32'h5, 32'h13);
      op_jump("jmp_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      op_idle("wrap", 32'h0);
      op_branch("br_wrap_low", 32'hFFFF_FFF0, 32'hFFFF_FFF1);

      set_in(1'b0, 1'b1, 32'h8, 1'b1, 32'h50, 1'b0, 1'b0);
      step("jmp_over_br", 32'h50);

      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 1'b1, 32'h4, 1'b1, 32'h70, 1'b1, 1'b0);
         step("stall", 32'h50);
         check_flags("stall", 1'b1, 1'b0, 1'b0);
      end

`ifdef PC_SEQUENCER_RAS_EN
      op_jump("jmp20", 32'h20, 32'h20);
      op_call("call100", 32'h100, 32'h100);
      check_flags("call1", 1'b0, 1'b0, 1'b0);
      op_call("call200", 32'h200, 32'h200);
      op_ret("ret1", 32'h101);
      op_ret("ret2", 32'h21);
      check_flags("ret2", 1'b1, 1'b0, 1'b0);

      op_jump("jmp1000", 32'h1000, 32'h1000);
      for (int i = 0; i < 5; i++) begin
         op_call("deep_call", W'((i + 2) * 32'h1000), W'((i + 2) * 32'h1000));
      end
      check_flags("deep_full", 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         op_ret("deep_ret", W'((5 - i) * 32'h1000 + 1));
         if (i == 0) check_flags("deep_ret0", 1'b0, 1'b0, 1'b0);
      end
      check_flags("deep_drained", 1'b1, 1'b0, 1'b0);
      op_ret("ret_empty", 32'h2002);
      check_flags("uflow_pulse", 1'b1, 1'b0, 1'b1);
      op_idle("after_uflow", 32'h2003);
      check_flags("uflow_clear", 1'b1, 1'b0, 1'b0);

      op_call("call300", 32'h300, 32'h300);
      set_in(1'b0, 1'b0, '0, 1'b0, 32'h400, 1'b1, 1'b1);
      step("call_ret", 32'h2004);
      check_flags("call_ret", 1'b1, 1'b0, 1'b0);

      op_call("call500", 32'h500, 32'h500);
      set_in(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      step("stall_ret", 32'h500);
      check_flags("stall_ret", 1'b0, 1'b0, 1'b0);
      op_ret("ret500", 32'h2005);
      check_flags("ret500", 1'b1, 1'b0, 1'b0);

      op_call("call600", 32'h600, 32'h600);
      set_in(1'b0, 1'b0, '0, 1'b0, 32'h700, 1'b1, 1'b0);
      #3 reset = 1'b1;
      #1;
      check("async_rst_pc", bus.pc, 32'h0);
      check_flags("async_rst", 1'b1, 1'b0, 1'b0);
      set_in(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
      #2 reset = 1'b0;
      op_ret("ret_after_rst", 32'h1);
      check_flags("ret_after_rst", 1'b1, 1'b0, 1'b1);
`else
      op_call("call40", 32'h40, 32'h40);
      check_flags("call40", 1'b1, 1'b0, 1'b0);
      op_ret("ret_seq", 32'h41);
      check_flags("ret_seq", 1'b1, 1'b0, 1'b0);
      set_in(1'b0, 1'b0, '0, 1'b0, 32'h80, 1'b1, 1'b1);
      step("call_ret", 32'h80);

      set_in(1'b0, 1'b0, '0, 1'b1, 32'h90, 1'b0, 1'b0);
      #3 reset = 1'b1;
      #1;
      check("async_rst_pc", bus.pc, 32'h0);
      check_flags("async_rst", 1'b1, 1'b0, 1'b0);
      set_in(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
      #2 reset = 1'b0;
      op_idle("idle_after_rst", 32'h1);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
